amp_power_sequencer: RTL and testbench

Parametrised power-up, configuration and fault-recovery sequencer for NUM_AMPS amplifier channels. It sits between the audio clocking front end and the amplifier control pins. It drives per-channel enable and mute, gates the shared config sender, and re-sequences the amplifiers after a fault up to a bounded retry count before locking out.

---
 rtl/amp_power_sequencer.sv | 170 +++++++++++++++++
 tb/tb_amp_power_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_power_sequencer.sv
// amp_power_sequencer: power-up, config gating and fault-retry sequencer for
// NUM_AMPS amplifier channels. Define AMP_SEQ_SYNC_EN for 2-flop input syncs.
module amp_power_sequencer #(
    parameter int NUM_AMPS          = 2,
    parameter int TIMER_W           = 16,
    parameter int EN_WAIT_CYCLES    = 1000,
    parameter int CFG_WAIT_CYCLES   = 1000,
    parameter int RETRY_WAIT_CYCLES = 5000,
    parameter int MAX_RETRIES       = 3
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                audio_locked_in,
    input  logic [NUM_AMPS-1:0] nerror_in,
    output logic [NUM_AMPS-1:0] nenable_out,
    output logic [NUM_AMPS-1:0] nmute_out,
    output logic                send_config_out,
    output logic                fault_out,
    output logic [NUM_AMPS-1:0] fault_ch_out,
    output logic [3:0]          retry_cnt_out,
    output logic [2:0]          state_out
);

    typedef enum logic [2:0] {
        S_INIT        = 3'd0,
        S_ENABLE_WAIT = 3'd1,
        S_CFG_WAIT    = 3'd2,
        S_RUN         = 3'd3,
        S_FAULT_WAIT  = 3'd4,
        S_LOCKOUT     = 3'd5
    } state_t;

    // A zero dwell behaves like a one-cycle dwell
    localparam logic [TIMER_W-1:0] LP_EN_LOAD =
        (EN_WAIT_CYCLES <= 1) ? '0 : TIMER_W'(EN_WAIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LP_CFG_LOAD =
        (CFG_WAIT_CYCLES <= 1) ? '0 : TIMER_W'(CFG_WAIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LP_RETRY_LOAD =
        (RETRY_WAIT_CYCLES <= 1) ? '0 : TIMER_W'(RETRY_WAIT_CYCLES - 1);
    localparam logic [4:0] LP_MAX_RETRY =
        (MAX_RETRIES > 15) ? 5'd16 : 5'(MAX_RETRIES);

    logic                w_locked;
    logic [NUM_AMPS-1:0] w_nerror;

`ifdef AMP_SEQ_SYNC_EN
    logic [1:0]          r_lock_sync;
    logic [NUM_AMPS-1:0] r_nerr_meta;
    logic [NUM_AMPS-1:0] r_nerr_sync;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_lock_sync <= '0;
            r_nerr_meta <= '1;
            r_nerr_sync <= '1;
        end else begin
            r_lock_sync <= {r_lock_sync[0], audio_locked_in};
            r_nerr_meta <= nerror_in;
            r_nerr_sync <= r_nerr_meta;
        end
    end

    assign w_locked = r_lock_sync[1];
    assign w_nerror = r_nerr_sync;
`else
    assign w_locked = audio_locked_in;
    assign w_nerror = nerror_in;
`endif

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [NUM_AMPS-1:0]  r_nenable;
    logic [NUM_AMPS-1:0]  r_nmute;
    logic                 r_send_cfg;
    logic                 r_fault;
    logic [NUM_AMPS-1:0]  r_fault_ch;
    logic [3:0]           r_retry;

    state_t               w_next;
    logic [TIMER_W-1:0]   w_timer_next;
    logic                 w_timer_zero;
    logic                 w_run_fault;
    logic                 w_retry_ok;
    logic                 w_amp_on;

    assign w_timer_zero = (r_timer == '0);
    assign w_run_fault  = (r_state == S_RUN) && !(&w_nerror);
    assign w_retry_ok   = ({1'b0, r_retry} < LP_MAX_RETRY);

    always_comb begin
        w_next       = r_state;
        w_timer_next = w_timer_zero ? '0 : r_timer - 1'b1;
        case (r_state)
            S_INIT: begin
                w_next       = S_ENABLE_WAIT;
                w_timer_next = LP_EN_LOAD;
            end
            S_ENABLE_WAIT: begin
                if (w_timer_zero) begin
                    w_next       = S_CFG_WAIT;
                    w_timer_next = LP_CFG_LOAD;
                end
            end
            S_CFG_WAIT: begin
                if (w_timer_zero) begin
                    w_next       = S_RUN;
                    w_timer_next = '0;
                end
            end
            S_RUN: begin
                if (w_run_fault) begin
                    w_next       = w_retry_ok ? S_FAULT_WAIT : S_LOCKOUT;
                    w_timer_next = LP_RETRY_LOAD;
                end
            end
            S_FAULT_WAIT: begin
                if (w_timer_zero) begin
                    w_next = S_INIT;
                end
            end
            S_LOCKOUT: begin
                w_next = S_LOCKOUT;
            end
            default: begin
                w_next       = S_INIT;
                w_timer_next = '0;
            end
        endcase
    end

    assign w_amp_on = (w_next == S_ENABLE_WAIT) ||
                      (w_next == S_CFG_WAIT) ||
                      (w_next == S_RUN);

    // Outputs decode the next state so they move on the same edge as state_out
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state    <= S_INIT;
            r_timer    <= '0;
            r_nenable  <= '1;
            r_nmute    <= '0;
            r_send_cfg <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_ch <= '0;
            r_retry    <= '0;
        end else begin
            r_state    <= w_next;
            r_timer    <= w_timer_next;
            r_nenable  <= w_amp_on ? '0 : '1;
            r_nmute    <= (w_next == S_RUN) ? {NUM_AMPS{w_locked}} : '0;
            r_send_cfg <= (w_next == S_CFG_WAIT) || (w_next == S_RUN);
            r_fault    <= (w_next == S_LOCKOUT);
            if (w_run_fault) begin
                r_fault_ch <= r_fault_ch | ~w_nerror;
                if (r_retry != 4'hF) begin
                    r_retry <= r_retry + 4'd1;
                end
            end
        end
    end

    assign nenable_out     = r_nenable;
    assign nmute_out       = r_nmute;
    assign send_config_out = r_send_cfg;
    assign fault_out       = r_fault;
    assign fault_ch_out    = r_fault_ch;
    assign retry_cnt_out   = r_retry;
    assign state_out       = r_state;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// tb_amp_power_sequencer: scoreboard bench for amp_power_sequencer
// (NUM_AMPS=2, dwells 4/3/5, MAX_RETRIES=2, no input synchronisers).
module tb_amp_power_sequencer;

    localparam int EN = 4;
    localparam int CW = 3;
    localparam int RW = 5;
    localparam int MR = 2;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] nen;
        logic [1:0] nmute;
        logic       cfg;
        logic       flt;
        logic [1:0] fch;
        logic [3:0] rc;
    } obs_t;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       audio_locked_in = 1'b1;
    logic [1:0] nerror_in = 2'b11;
    logic [1:0] nenable_out;
    logic [1:0] nmute_out;
    logic       send_config_out;
    logic       fault_out;
    logic [1:0] fault_ch_out;
    logic [3:0] retry_cnt_out;
    logic [2:0] state_out;

    int n_vec = 0;
    int n_err = 0;

    obs_t q[$];
    int         m_st;
    int         m_age;
    int         m_rc;
    logic [1:0] m_fch;

    amp_power_sequencer #(
        .NUM_AMPS(2),
        .TIMER_W(16),
        .EN_WAIT_CYCLES(EN),
        .CFG_WAIT_CYCLES(CW),
        .RETRY_WAIT_CYCLES(RW),
        .MAX_RETRIES(MR)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .audio_locked_in(audio_locked_in),
        .nerror_in(nerror_in),
        .nenable_out(nenable_out),
        .nmute_out(nmute_out),
        .send_config_out(send_config_out),
        .fault_out(fault_out),
        .fault_ch_out(fault_ch_out),
        .retry_cnt_out(retry_cnt_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic obs_t observe();
        return {state_out, nenable_out, nmute_out, send_config_out,
                fault_out, fault_ch_out, retry_cnt_out};
    endfunction

    task automatic model_reset();
        m_st  = 0;
        m_age = 0;
        m_rc  = 0;
        m_fch = 2'b00;
        q.delete();
    endtask

    // Behavioural model: age counts cycles spent in the current dwell state
    task automatic model_push(input logic lock, input logic [1:0] nerr);
        obs_t e;
        int ns;
        ns = m_st;
        case (m_st)
            0: begin ns = 1; m_age = 1; end
            1: if (m_age == EN) begin ns = 2; m_age = 1; end else m_age++;
            2: if (m_age == CW) begin ns = 3; m_age = 1; end else m_age++;
            3: if (nerr != 2'b11) begin
                m_fch = m_fch | ~nerr;
                ns = (m_rc < MR) ? 4 : 5;
                m_age = 1;
                if (m_rc < 15) m_rc++;
            end
            4: if (m_age == RW) ns = 0; else m_age++;
            5: ns = 5;
            default: ns = 0;
        endcase
        m_st    = ns;
        e.st    = 3'(ns);
        e.nen   = (ns >= 1 && ns <= 3) ? 2'b00 : 2'b11;
        e.nmute = (ns == 3) ? {2{lock}} : 2'b00;
        e.cfg   = (ns == 2) || (ns == 3);
        e.flt   = (ns == 5);
        e.fch   = m_fch;
        e.rc    = 4'(m_rc);
        q.push_back(e);
    endtask

    task automatic tick(input logic lock, input logic [1:0] nerr,
                        output obs_t got, output obs_t exp);
        audio_locked_in = lock;
        nerror_in = nerr;
        model_push(lock, nerr);
        @(posedge clk_in);
        #1;
        got = observe();
        exp = q.pop_front();
    endtask

    task automatic test_reset();
        obs_t g;
        obs_t rst_exp;
        rst_exp = {3'd0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0};
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        g = observe();
        n_vec++;
        if (g !== rst_exp) begin
            n_err++;
            $display("FAIL reset got %b expected %b", g, rst_exp);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_powerup();
        obs_t g;
        obs_t e;
        for (int c = 1; c <= 8; c++) begin
            tick(1'b1, 2'b11, g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL powerup[%0d] got %b expected %b", c, g, e);
            end
            if (c == 1) begin
                n_vec++;
                if (g.nen !== 2'b00) begin
                    n_err++;
                    $display("FAIL powerup_en got %b expected 00", g.nen);
                end
            end
            if (c == 4 || c == 5) begin
                n_vec++;
                if (g.cfg !== (c == 5)) begin
                    n_err++;
                    $display("FAIL powerup_cfg[%0d] got %b", c, g.cfg);
                end
            end
            if (c == 8) begin
                n_vec++;
                if (g.nmute !== 2'b11 || g.st !== 3'd3) begin
                    n_err++;
                    $display("FAIL powerup_run got st=%0d nmute=%b expected 3/11",
                             g.st, g.nmute);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        obs_t g;
        obs_t e;
        int muted;
        int left_run;
        muted = 0;
        left_run = 0;
        for (int c = 0; c < 6; c++) begin
            tick(c >= 3, 2'b11, g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL lock_loss[%0d] got %b expected %b", c, g, e);
            end
            if (g.nmute == 2'b00) muted++;
            if (g.st != 3'd3) left_run++;
        end
        n_vec++;
        if (muted != 3 || left_run != 0) begin
            n_err++;
            $display("FAIL lock_loss_span got muted=%0d nonrun=%0d expected 3/0",
                     muted, left_run);
        end
    endtask

    task automatic test_fault_retry();
        obs_t g;
        obs_t e;
        tick(1'b1, 2'b10, g, e);
        n_vec++;
        if (g !== e || g.st !== 3'd4 || g.nen !== 2'b11 ||
            g.fch !== 2'b01 || g.rc !== 4'd1) begin
            n_err++;
            $display("FAIL fault1 got %b expected %b", g, e);
        end
        for (int i = 1; i <= 13; i++) begin
            tick(1'b1, 2'b11, g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL fault1_recover[%0d] got %b expected %b", i, g, e);
            end
            if (i == 5 || i == 12 || i == 13) begin
                n_vec++;
                if (g.st !== ((i == 5) ? 3'd0 : (i == 12) ? 3'd2 : 3'd3)) begin
                    n_err++;
                    $display("FAIL fault1_timeline[%0d] got st=%0d", i, g.st);
                end
            end
        end
    endtask

    task automatic test_startup_ignore();
        obs_t g;
        obs_t e;
        tick(1'b1, 2'b10, g, e);
        n_vec++;
        if (g !== e || g.rc !== 4'd2 || g.fch !== 2'b01) begin
            n_err++;
            $display("FAIL fault2 got %b expected %b", g, e);
        end
        for (int i = 1; i <= 13; i++) begin
            tick(1'b1, 2'b00, g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL startup_noise[%0d] got %b expected %b", i, g, e);
            end
        end
        n_vec++;
        if (g.st !== 3'd3 || g.rc !== 4'd2 || g.fch !== 2'b01) begin
            n_err++;
            $display("FAIL startup_ignore got st=%0d rc=%0d fch=%b expected 3/2/01",
                     g.st, g.rc, g.fch);
        end
    endtask

    task automatic test_lockout();
        obs_t g;
        obs_t e;
        int escaped;
        escaped = 0;
        tick(1'b0, 2'b01, g, e);
        n_vec++;
        if (g !== e || g.st !== 3'd5 || g.flt !== 1'b1 ||
            g.rc !== 4'd3 || g.fch !== 2'b11) begin
            n_err++;
            $display("FAIL lockout_entry got %b expected %b", g, e);
        end
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL lockout_hold[%0d] got %b expected %b", i, g, e);
            end
            if (g.st != 3'd5) escaped++;
        end
        n_vec++;
        if (escaped != 0) begin
            n_err++;
            $display("FAIL lockout_escape got %0d expected 0", escaped);
        end
    endtask

    task automatic test_reset_mid();
        obs_t g;
        obs_t e;
        obs_t rst_exp;
        rst_exp = {3'd0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0};
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        model_reset();
        for (int c = 1; c <= 6; c++) begin
            tick(1'b1, 2'b00, g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL noise_startup[%0d] got %b expected %b", c, g, e);
            end
        end
        n_vec++;
        if (g.st !== 3'd2 || g.fch !== 2'b00) begin
            n_err++;
            $display("FAIL cfg_before_reset got st=%0d fch=%b", g.st, g.fch);
        end
        #2;
        reset = 1'b0;
        #1;
        g = observe();
        n_vec++;
        if (g !== rst_exp) begin
            n_err++;
            $display("FAIL async_reset got %b expected %b", g, rst_exp);
        end
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        model_reset();
        for (int c = 1; c <= 8; c++) begin
            tick(1'b1, 2'b11, g, e);
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL repower[%0d] got %b expected %b", c, g, e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_powerup();
        test_lock_loss();
        test_fault_retry();
        test_startup_ignore();
        test_lockout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
